// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the fetch address and arbitrates trap, redirect and
// sequential advance. It also supports stall, halt/resume, a redirect buffered while stalled
// or halted, and a sticky misalignment flag.
module pc_sequencer #(
  parameter int unsigned            WIDTH        = 32,
  parameter logic [WIDTH-1:0]       RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]       TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int unsigned            INC          = 4,
  parameter int unsigned            ALIGN_BITS   = 2   // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             write,
  input  logic [WIDTH-1:0] new_count,
  input  logic             trap,
  input  logic             halt,
  input  logic             resume,
  input  logic             fetch_ack,
  output logic [WIDTH-1:0] addr,
  output logic             fetch_req,
  output logic             pc_update,
  output logic             misalign,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StBoot   = 2'b00,
    StRun    = 2'b01,
    StHalted = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             mis_q, mis_d;
  logic             upd_q, upd_d;

  // A direct write takes precedence over an older buffered target.
  logic [WIDTH-1:0] tgt;
  logic             tgt_bad;

  // Select the redirect target and check its alignment.
  always_comb begin
    tgt     = write ? new_count : pend_q;
    tgt_bad = |tgt[ALIGN_BITS-1:0];
  end

  // Next-state logic: trap > halt > redirect/pending > sequential advance.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    mis_d    = mis_q;
    upd_d    = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (trap) begin
          addr_d   = TRAP_VECTOR;
          pend_v_d = 1'b0;
          upd_d    = 1'b1;
        end else if (halt) begin
          // Freeze on entry; a simultaneous write is kept for after resume.
          if (write) begin
            pend_d   = new_count;
            pend_v_d = 1'b1;
          end
          state_d = StHalted;
        end else if (write && stall) begin
          pend_d   = new_count;
          pend_v_d = 1'b1;
        end else if ((write || pend_v_q) && !stall) begin
          addr_d   = tgt_bad ? TRAP_VECTOR : tgt;
          mis_d    = mis_q | tgt_bad;
          pend_v_d = 1'b0;
          upd_d    = 1'b1;
        end else if (fetch_ack && !stall) begin
          addr_d = addr_q + WIDTH'(INC);
          upd_d  = 1'b1;
        end
      end
      StHalted: begin
        if (trap) begin
          addr_d   = TRAP_VECTOR;
          pend_v_d = 1'b0;
          upd_d    = 1'b1;
          state_d  = StRun;
        end else begin
          if (write) begin
            pend_d   = new_count;
            pend_v_d = 1'b1;
          end
          if (resume) state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBoot;
      addr_q   <= RESET_VECTOR;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      mis_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      mis_q    <= mis_d;
      upd_q    <= upd_d;
    end
  end

  // Outputs come straight from registers; only fetch_req decodes the state.
  always_comb begin
    addr      = addr_q;
    fetch_req = (state_q == StRun);
    pc_update = upd_q;
    misalign  = mis_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes the expected outputs when
// stimulus is driven, and they are popped and compared one edge later.
module tb_pc_sequencer;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, write, trap, halt, resume, fetch_ack;
  logic [31:0] new_count, addr;
  logic        fetch_req, pc_update, misalign;
  logic [1:0]  state;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .write(write), .new_count(new_count),
    .trap(trap), .halt(halt), .resume(resume), .fetch_ack(fetch_ack),
    .addr(addr), .fetch_req(fetch_req), .pc_update(pc_update), .misalign(misalign),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  state;
    logic        upd;
    logic        mis;
    logic        freq;
  } want_t;

  want_t sb[$];
  int    checks = 0;
  int    failures = 0;

  // Behavioural model state.
  logic [31:0] m_addr, m_pend;
  logic [1:0]  m_state;
  logic        m_pend_v, m_mis, m_upd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic push_want();
    want_t w;
    w.addr  = m_addr;
    w.state = m_state;
    w.upd   = m_upd;
    w.mis   = m_mis;
    w.freq  = (m_state == 2'b01);
    sb.push_back(w);
  endtask

  task automatic compare();
    want_t w;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'd0, 32'd1);
      return;
    end
    w = sb.pop_front();
    check_val("addr", addr, w.addr);
    check_val("state", {30'd0, state}, {30'd0, w.state});
    check_val("pc_update", {31'd0, pc_update}, {31'd0, w.upd});
    check_val("misalign", {31'd0, misalign}, {31'd0, w.mis});
    check_val("fetch_req", {31'd0, fetch_req}, {31'd0, w.freq});
  endtask

  task automatic model_reset();
    m_addr = 32'd0; m_state = 2'b00; m_pend_v = 1'b0; m_pend = 32'd0;
    m_mis = 1'b0; m_upd = 1'b0;
  endtask

  // Apply a redirect target, trapping if it is misaligned.
  task automatic model_apply(input logic [31:0] t);
    if (t[1:0] != 2'b00) begin
      m_addr = TV;
      m_mis  = 1'b1;
    end else begin
      m_addr = t;
    end
    m_pend_v = 1'b0;
    m_upd    = 1'b1;
  endtask

  task automatic model_step();
    m_upd = 1'b0;
    if (m_state == 2'b00) begin
      m_state = 2'b01;
    end else if (m_state == 2'b01) begin
      if (trap) begin
        m_addr = TV; m_pend_v = 1'b0; m_upd = 1'b1;
      end else if (halt) begin
        if (write) begin m_pend = new_count; m_pend_v = 1'b1; end
        m_state = 2'b10;
      end else if (stall) begin
        if (write) begin m_pend = new_count; m_pend_v = 1'b1; end
      end else if (write) begin
        model_apply(new_count);
      end else if (m_pend_v) begin
        model_apply(m_pend);
      end else if (fetch_ack) begin
        m_addr = m_addr + 32'd4; m_upd = 1'b1;
      end
    end else begin
      if (trap) begin
        m_addr = TV; m_pend_v = 1'b0; m_upd = 1'b1; m_state = 2'b01;
      end else begin
        if (write) begin m_pend = new_count; m_pend_v = 1'b1; end
        if (resume) m_state = 2'b01;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic cycle(input logic s, input logic w, input logic [31:0] nc, input logic t,
                       input logic h, input logic r, input logic a);
    stall = s; write = w; new_count = nc; trap = t; halt = h; resume = r; fetch_ack = a;
    model_step();
    push_want();
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; write = 1'b0; new_count = 32'd0; trap = 1'b0;
    halt = 1'b0; resume = 1'b0; fetch_ack = 1'b0;
    model_reset();

    // Reset and boot.
    repeat (2) @(posedge clk);
    #1;
    push_want(); compare();
    rst = 1'b0;
    #1;
    push_want(); compare();
    cycle(0, 0, 32'd0, 0, 0, 0, 0);              // BOOT -> RUN

    // Sequential advance, then hold.
    repeat (3) cycle(0, 0, 32'd0, 0, 0, 0, 1);   // 0x4, 0x8, 0xC
    cycle(0, 0, 32'd0, 0, 0, 0, 0);              // hold

    // Redirects, aligned and misaligned.
    cycle(0, 1, 32'h0000_1000, 0, 0, 0, 1);
    cycle(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);      // -> TRAP_VECTOR, misalign

    // Redirect buffered during stall.
    repeat (3) cycle(1, 1, 32'h0000_0200, 0, 0, 0, 1);
    cycle(0, 0, 32'd0, 0, 0, 0, 1);              // pending applied -> 0x200

    // Wrap and trap-over-write.
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cycle(0, 0, 32'd0, 0, 0, 0, 1);              // wraps to 0
    cycle(0, 1, 32'h0000_0300, 1, 0, 0, 1);      // trap wins
    cycle(0, 1, 32'h0000_0100, 0, 0, 0, 0);      // same value still pulses

    // Halt with write, frozen, resume, pending applied after stall.
    cycle(0, 1, 32'h0000_0040, 0, 1, 0, 1);
    repeat (2) cycle(0, 0, 32'd0, 0, 0, 0, 1);
    cycle(0, 0, 32'd0, 0, 0, 1, 1);
    cycle(1, 0, 32'd0, 0, 0, 0, 1);
    cycle(0, 0, 32'd0, 0, 0, 0, 1);              // -> 0x40

    // Trap with halt stays in RUN; trap from HALTED returns to RUN.
    cycle(0, 0, 32'd0, 1, 1, 0, 1);
    cycle(0, 0, 32'd0, 0, 1, 0, 1);
    cycle(0, 1, 32'h0000_0800, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] nc;
      nc = $urandom();
      if ($urandom_range(0, 7) != 0) nc[1:0] = 2'b00;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, nc,
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-RUN.
    cycle(0, 0, 32'd0, 0, 0, 1, 1);
    rst = 1'b1;
    #1;
    model_reset();
    push_want(); compare();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 0, 32'd0, 0, 0, 0, 1);              // BOOT -> RUN
    cycle(0, 0, 32'd0, 0, 0, 0, 1);              // 0x4

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
